// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared types and helpers for the MEM-stage load/store initiator.
//   state_e  : access FSM states (REQ2/WAIT2 are only reachable when the
//              MEM_ACCESS_SPLIT_EN macro is defined)
//   F3_*     : func3 encodings understood by the unit
//   size_e   : access size (byte / half / word)
// Helpers decode func3 into size and signedness and classify alignment.
// ---------------------------------------------------------------------------
package mem_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_REQ2  = 3'd4,
    ST_WAIT2 = 3'd5
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Any func3 outside the five known codes is treated as a word access.
  function automatic size_e decodeSize(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_B;
      F3_LH, F3_LHU: return SZ_H;
      default:       return SZ_W;
    endcase
  endfunction

  function automatic logic isUnsignedLoad(input logic [2:0] f3);
    return (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Halves must sit on an even byte, words on a word boundary.
  function automatic logic isMisaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align  (purely combinational)
// Byte-lane steering for the memory access unit.
//   Store side (driven from the live pipeline request):
//     stSize_i, stOff_i  access size and byte offset inside the word
//     stSecond_i         1 = produce enables for the second word of a split
//     stSplit_i          1 = misaligned split access, rotate write data
//     wd_i               store data from the pipeline
//     be_o               byte enables for the current word
//     wdata_o            lane-replicated (or rotated, when split) write data
//   Load side (driven from the registered request):
//     ldSize_i, ldUnsigned_i, ldOff_i  size, zero-extend flag, byte offset
//     rdataLo_i, rdataHi_i             first / second read word
//     loadData_o                       extracted and extended load result
// ---------------------------------------------------------------------------
module mem_lane_align
  import mem_access_pkg::*;
(
  input  size_e       stSize_i,
  input  logic [1:0]  stOff_i,
  input  logic        stSecond_i,
  input  logic        stSplit_i,
  input  logic [31:0] wd_i,
  input  size_e       ldSize_i,
  input  logic        ldUnsigned_i,
  input  logic [1:0]  ldOff_i,
  input  logic [31:0] rdataLo_i,
  input  logic [31:0] rdataHi_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] loadData_o
);

  logic [3:0]  beBase;
  logic [7:0]  beWide;
  logic [31:0] wdRep;
  logic [31:0] wdRot;
  logic [31:0] ldWord;

  // Byte enables are built over a two-word window: the size mask shifted by
  // the offset. The low nibble covers lanes >= off in the first word and the
  // high nibble is whatever spilled into the following word.
  always_comb begin
    beBase = 4'b1111;
    case (stSize_i)
      SZ_B:    beBase = 4'b0001;
      SZ_H:    beBase = 4'b0011;
      default: beBase = 4'b1111;
    endcase
    beWide = {4'b0000, beBase} << stOff_i;
    be_o   = stSecond_i ? beWide[7:4] : beWide[3:0];
  end

  // Aligned stores replicate the datum into every lane so the byte enables
  // alone pick the destination. A split store instead rotates the datum left
  // by the offset, which puts every byte on the right lane of both words.
  always_comb begin
    wdRep = wd_i;
    case (stSize_i)
      SZ_B:    wdRep = {4{wd_i[7:0]}};
      SZ_H:    wdRep = {2{wd_i[15:0]}};
      default: wdRep = wd_i;
    endcase
    wdRot   = 32'({wd_i, wd_i} >> (6'd32 - {1'b0, stOff_i, 3'b000}));
    wdata_o = stSplit_i ? wdRot : wdRep;
  end

  // Loads view the two read words as one 64-bit little-endian window and
  // shift the addressed byte down to bit 0; for a single-word access both
  // halves carry the same word and only the low one matters.
  always_comb begin
    ldWord     = 32'({rdataHi_i, rdataLo_i} >> {ldOff_i, 3'b000});
    loadData_o = ldWord;
    case (ldSize_i)
      SZ_B:    loadData_o = ldUnsigned_i ? {24'b0, ldWord[7:0]}
                                         : {{24{ldWord[7]}}, ldWord[7:0]};
      SZ_H:    loadData_o = ldUnsigned_i ? {16'b0, ldWord[15:0]}
                                         : {{16{ldWord[15]}}, ldWord[15:0]};
      default: loadData_o = ldWord;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MEM-stage load/store initiator on a word-addressed valid/ready data bus.
// Turns MemRead/MemWrite/func3/addr/wd into word address, byte enables and
// lane-replicated write data, waits for the bus response (stores wait for a
// write ack too), and returns sign/zero-extended load data.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   MemRead, MemWrite load / store request (read wins when both are set)
//   func3, addr, wd   access type, byte address, store data
//   stall             holds IF..MEM while an access is being accepted/served
//   done              one-cycle completion pulse
//   load_data         registered load result, held until the next load done
//   misalign          one-cycle pulse with done for a rejected misaligned access
//   m_req_valid/ready request handshake; m_we, m_addr, m_be, m_wdata fields
//   m_rsp_valid       read data / write ack; m_rdata read word
//
// Configuration
//   MEM_ACCESS_SPLIT_EN  defined: misaligned accesses become two word
//                        transactions (w, then w+1) and misalign is tied 0.
//                        undefined: misaligned accesses issue no bus traffic
//                        and complete with a done+misalign pulse.
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            func3,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wd,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_W-1:0]     load_data,
  output logic                  misalign,
  output logic                  m_req_valid,
  input  logic                  m_req_ready,
  output logic                  m_we,
  output logic [DM_ADDRESS-1:0] m_addr,
  output logic [3:0]            m_be,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_rsp_valid,
  input  logic [DATA_W-1:0]     m_rdata
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  size_e                 ldSize_q, ldSize_d;
  logic                  ldUns_q, ldUns_d;
  logic [1:0]            ldOff_q, ldOff_d;
  logic                  isLoad_q, isLoad_d;
  logic [DATA_W-1:0]     loadData_q, loadData_d;
`ifdef MEM_ACCESS_SPLIT_EN
  logic                  split_q, split_d;
  logic [DATA_W-1:0]     rdata1_q, rdata1_d;
`else
  logic                  misalign_q, misalign_d;
`endif

  logic                  access;
  size_e                 curSize;
  logic [1:0]            curOff;
  logic                  curMis;
  logic                  busy;
  logic                  laneSecond;
  logic                  laneSplit;
  logic [DATA_W-1:0]     laneRdLo;
  logic [3:0]            laneBe;
  logic [DATA_W-1:0]     laneWdata;
  logic [DATA_W-1:0]     laneLoad;
  logic                  unusedAddrBits;

  // Decode of the live pipeline request; only consumed while IDLE (and for
  // the second-word enables of a split, while the pipeline is stalled).
  assign access  = MemRead | MemWrite;
  assign curSize = decodeSize(func3);
  assign curOff  = addr[1:0];
  assign curMis  = isMisaligned(curSize, curOff);

  assign unusedAddrBits = ^addr[ADDR_W-1:DM_ADDRESS+2];

`ifdef MEM_ACCESS_SPLIT_EN
  assign laneSecond = (state_q == ST_WAIT) && split_q;
  assign laneSplit  = curMis;
  assign laneRdLo   = split_q ? rdata1_q : m_rdata;
`else
  assign laneSecond = 1'b0;
  assign laneSplit  = 1'b0;
  assign laneRdLo   = m_rdata;
`endif

  mem_lane_align u_lane (
    .stSize_i     (curSize),
    .stOff_i      (curOff),
    .stSecond_i   (laneSecond),
    .stSplit_i    (laneSplit),
    .wd_i         (wd),
    .ldSize_i     (ldSize_q),
    .ldUnsigned_i (ldUns_q),
    .ldOff_i      (ldOff_q),
    .rdataLo_i    (laneRdLo),
    .rdataHi_i    (m_rdata),
    .be_o         (laneBe),
    .wdata_o      (laneWdata),
    .loadData_o   (laneLoad)
  );

  // State and request-field registers. Reset abandons any transaction in
  // flight; a response arriving afterwards finds the FSM outside WAIT and is
  // simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      ldSize_q   <= SZ_B;
      ldUns_q    <= 1'b0;
      ldOff_q    <= 2'b00;
      isLoad_q   <= 1'b0;
      loadData_q <= '0;
`ifdef MEM_ACCESS_SPLIT_EN
      split_q    <= 1'b0;
      rdata1_q   <= '0;
`else
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      ldSize_q   <= ldSize_d;
      ldUns_q    <= ldUns_d;
      ldOff_q    <= ldOff_d;
      isLoad_q   <= isLoad_d;
      loadData_q <= loadData_d;
`ifdef MEM_ACCESS_SPLIT_EN
      split_q    <= split_d;
      rdata1_q   <= rdata1_d;
`else
      misalign_q <= misalign_d;
`endif
    end
  end

  // Next-state logic. IDLE snapshots the request so the bus fields stay
  // frozen through REQ no matter how long m_req_ready takes. Load data is
  // written on the way into DONE so it is already valid during the done
  // pulse; stores leave the previous load result untouched.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    ldSize_d   = ldSize_q;
    ldUns_d    = ldUns_q;
    ldOff_d    = ldOff_q;
    isLoad_d   = isLoad_q;
    loadData_d = loadData_q;
`ifdef MEM_ACCESS_SPLIT_EN
    split_d    = split_q;
    rdata1_d   = rdata1_q;
`else
    misalign_d = misalign_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (access) begin
          we_d     = ~MemRead;
          addr_d   = addr[DM_ADDRESS+1:2];
          be_d     = laneBe;
          wdata_d  = laneWdata;
          ldSize_d = curSize;
          ldUns_d  = isUnsignedLoad(func3);
          ldOff_d  = curOff;
          isLoad_d = MemRead;
`ifdef MEM_ACCESS_SPLIT_EN
          split_d  = curMis;
          state_d  = ST_REQ;
`else
          misalign_d = curMis;
          if (curMis) begin
            if (MemRead) begin
              loadData_d = '0;
            end
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
          end
`endif
        end
      end

      ST_REQ: begin
        if (m_req_ready) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (m_rsp_valid) begin
`ifdef MEM_ACCESS_SPLIT_EN
          if (split_q) begin
            rdata1_d = m_rdata;
            addr_d   = addr_q + 1'b1;
            be_d     = laneBe;
            state_d  = ST_REQ2;
          end else begin
            if (isLoad_q) begin
              loadData_d = laneLoad;
            end
            state_d = ST_DONE;
          end
`else
          if (isLoad_q) begin
            loadData_d = laneLoad;
          end
          state_d = ST_DONE;
`endif
        end
      end

`ifdef MEM_ACCESS_SPLIT_EN
      ST_REQ2: begin
        if (m_req_ready) begin
          state_d = ST_WAIT2;
        end
      end

      ST_WAIT2: begin
        if (m_rsp_valid) begin
          if (isLoad_q) begin
            loadData_d = laneLoad;
          end
          state_d = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stall is qualified with rst_n so that asserting reset releases the
  // pipeline immediately, even while a request is still being presented.
  assign busy = (state_q == ST_REQ)  || (state_q == ST_WAIT) ||
                (state_q == ST_REQ2) || (state_q == ST_WAIT2);
  assign stall = rst_n & (((state_q == ST_IDLE) & access) | busy);

  assign done        = (state_q == ST_DONE);
  assign m_req_valid = (state_q == ST_REQ) || (state_q == ST_REQ2);
  assign m_we        = we_q;
  assign m_addr      = addr_q;
  assign m_be        = be_q;
  assign m_wdata     = wdata_q;
  assign load_data   = loadData_q;

`ifdef MEM_ACCESS_SPLIT_EN
  assign misalign = 1'b0;
`else
  assign misalign = done & misalign_q;
`endif

endmodule
